axi4s_frame_decoder: RTL and testbench
======================================

Name: axi4s_frame_decoder

Overview:
- Single-FSM receive-path decoder, successor to the split deframer/de-escaper chain.
- Hunts START, strips escapes, and drops STOP.
- Optionally checks a trailing CRC-8 and enforces a maximum frame length.
- Reports per-frame status on initiator_tuser with the tlast beat and keeps saturating frame counters; sits between the byte-level UART stream and frame consumers.

Parameters:
- ESCAPE_BYTE, 8'h7F: escape marker.
- START_BYTE, 8'h7D: frame start marker.
- STOP_BYTE, 8'h7E: frame stop marker.
- MAX_LEN, 256: max de-escaped bytes per frame, CRC byte included; range 2..65535.
- CRC_EN, 1: 1 means the last de-escaped byte is a CRC-8 and is checked, then removed; 0 means no CRC.
- CRC_POLY, 8'h07: CRC-8 polynomial, MSB-first, init 8'h00.

Ports:
- aclk, in, 1: clock.
- areset, in, 1: asynchronous reset, active-high.
- target_tvalid, in, 1: byte stream valid.
- target_tready, out, 1: byte stream ready.
- target_tdata, in, 8: raw byte.
- initiator_tvalid, out, 1: payload valid.
- initiator_tready, in, 1: payload ready.
- initiator_tdata, out, 8: de-escaped payload byte.
- initiator_tlast, out, 1: last payload byte of frame.
- initiator_tuser, out, 2: valid only on tlast beat. [0] = CRC error; [1] = abort (restart or overflow).
- frames_ok, out, 16: count of frames closed with tuser==0; saturates at 16'hFFFF.
- frames_err, out, 16: count of erroneous, aborted or short frames; saturates.

Behaviour:
- Reset (async, active-high): FSM=HUNT, hold buffer empty, CRC=0, length=0, all outputs 0.
- Reset mid-frame: partial frame discarded, no tlast emitted.
- Handshake: target_tready = !initiator_tvalid | initiator_tready.
  - Each accepted byte causes at most one output beat.
  - The output register loads in the cycle after acceptance.
  - initiator_* stay stable while tvalid & !tready.
- States:
  - HUNT: discard all bytes except START → DATA (clear CRC, length, hold, emitted flag).
  - DATA:
    - ESCAPE → ESC.
    - START → abort(restart), stay DATA, fresh frame.
    - STOP → close.
    - Any other byte → push.
  - ESC: next byte taken literally (any value, including START/STOP/ESCAPE) → push, → DATA.
- Push:
  - Update CRC with the byte; length += 1.
  - Hold-back depth is 2 when CRC_EN=1, 1 when CRC_EN=0.
  - If the hold buffer is full, the oldest byte is emitted with tlast=0 and the emitted flag is set.
  - If length exceeds MAX_LEN → abort(overflow), → HUNT.
- Close:
  - CRC_EN=1, length>=2: emit oldest held byte (last payload byte) with tlast=1 and tuser[0] = (CRC residue != 0); the CRC byte is dropped.
  - CRC_EN=0, length>=1: emit held byte with tlast=1, tuser=0.
  - Too short (CRC_EN=1 with length<2, or CRC_EN=0 with length==0): no beat emitted.
    - CRC_EN=1 and length 0 or 1: frames_err+1.
    - CRC_EN=0 and length 0: silent, no count.
  - Then → HUNT.
  - frames_ok+1 if tuser==0, else frames_err+1.
- Abort:
  - If emitted flag is set: emit oldest held byte with tlast=1, tuser=2'b10 (tuser[0] forced 0).
  - Otherwise: no beat.
  - Always frames_err+1.
- Both counters update in the cycle the closing STOP or aborting byte is accepted.
  - Each saturates independently at 16'hFFFF.
- No tuser value other than on tlast beats is specified; drive 0.

Test Plan:
- CRC_EN=1, in 7D 01 02 1B 7E → beats 01(tlast=0), 02(tlast=1,tuser=00); frames_ok=1.
- Same with CRC byte 1C → 02 carries tlast=1, tuser=01; frames_err=1, frames_ok unchanged.
- Escapes: in 7D 7F 7E 7F 7D 7E (payload 7E, CRC 7D) → single beat 7E, tlast=1, tuser=00.
- Restart: in 7D 11 22 33 7D 44 C8? 7E with bad CRC → 11 emitted, then 22 with tlast=1, tuser=10; second frame 44 with tuser=01; frames_err=2.
- Overflow: MAX_LEN=4, frame of 6 payload bytes → 3 beats, the third with tlast=1, tuser=10. Subsequent bytes are ignored until the next START.
- Backpressure/reset: hold initiator_tready=0 for 5 cycles mid-frame → target_tready=0 and output stable. Assert areset mid-frame → all outputs 0, next valid frame decodes cleanly.

Source files
------------

// File: rtl/axi4s_frame_decoder.sv
// Receive-path frame decoder: hunts START, strips escapes, drops STOP, optionally
// checks a trailing CRC-8, enforces MAX_LEN and reports per-frame status on tuser.
module axi4s_frame_decoder #(
  parameter logic [7:0]  ESCAPE_BYTE = 8'h7F,
  parameter logic [7:0]  START_BYTE  = 8'h7D,
  parameter logic [7:0]  STOP_BYTE   = 8'h7E,
  parameter int unsigned MAX_LEN     = 256,
  parameter bit          CRC_EN      = 1'b1,
  parameter logic [7:0]  CRC_POLY    = 8'h07
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        target_tvalid,
  output logic        target_tready,
  input  logic [7:0]  target_tdata,
  output logic        initiator_tvalid,
  input  logic        initiator_tready,
  output logic [7:0]  initiator_tdata,
  output logic        initiator_tlast,
  output logic [1:0]  initiator_tuser,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ESC  = 2'd2;

  // The CRC byte must stay held back so it never reaches the output.
  localparam logic [1:0] DEPTH = CRC_EN ? 2'd2 : 2'd1;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int unsigned i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  crc_q, crc_d;
  logic [16:0] len_q, len_d;
  logic        emitted_q, emitted_d;

  logic        accept, push, close, abort, fresh;
  logic        beat, beat_last;
  logic [7:0]  beat_data;
  logic [1:0]  beat_user;
  logic        inc_ok, inc_err;

  assign target_tready = !initiator_tvalid || initiator_tready;
  assign accept        = target_tvalid && target_tready;

  always_comb begin
    state_d   = state_q;
    hold0_d   = hold0_q;
    hold1_d   = hold1_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    len_d     = len_q;
    emitted_d = emitted_q;
    push      = 1'b0;
    close     = 1'b0;
    abort     = 1'b0;
    fresh     = 1'b0;
    beat      = 1'b0;
    beat_last = 1'b0;
    beat_data = hold0_q;
    beat_user = 2'b00;
    inc_ok    = 1'b0;
    inc_err   = 1'b0;

    if (accept) begin
      case (state_q)
        S_HUNT: if (target_tdata == START_BYTE) begin
          state_d = S_DATA;
          fresh   = 1'b1;
        end
        S_DATA: begin
          if (target_tdata == ESCAPE_BYTE) begin
            state_d = S_ESC;
          end else if (target_tdata == START_BYTE) begin
            abort = 1'b1;
            fresh = 1'b1;
          end else if (target_tdata == STOP_BYTE) begin
            close   = 1'b1;
            state_d = S_HUNT;
          end else begin
            push = 1'b1;
          end
        end
        S_ESC: begin
          push    = 1'b1;
          state_d = S_DATA;
        end
        default: state_d = S_HUNT;
      endcase
    end

    // Overflow is detected before the byte is stored, so the abort beat
    // carries the oldest byte already held, not the overflowing one.
    if (push) begin
      if (len_q + 17'd1 > 17'(MAX_LEN)) begin
        abort   = 1'b1;
        state_d = S_HUNT;
      end else begin
        crc_d = crc8_next(crc_q, target_tdata);
        len_d = len_q + 17'd1;
        if (cnt_q == DEPTH) begin
          beat      = 1'b1;
          emitted_d = 1'b1;
          if (DEPTH == 2'd2) begin
            hold0_d = hold1_q;
            hold1_d = target_tdata;
          end else begin
            hold0_d = target_tdata;
          end
        end else begin
          if (cnt_q == 2'd0) hold0_d = target_tdata;
          else               hold1_d = target_tdata;
          cnt_d = cnt_q + 2'd1;
        end
      end
    end

    if (abort) begin
      inc_err = 1'b1;
      if (emitted_q) begin
        beat      = 1'b1;
        beat_last = 1'b1;
        beat_user = 2'b10;
      end
    end

    if (close) begin
      if (CRC_EN) begin
        if (len_q >= 17'd2) begin
          beat      = 1'b1;
          beat_last = 1'b1;
          beat_user = {1'b0, crc_q != 8'h00};
          inc_ok    = (crc_q == 8'h00);
          inc_err   = (crc_q != 8'h00);
        end else begin
          inc_err = 1'b1;
        end
      end else if (len_q >= 17'd1) begin
        beat      = 1'b1;
        beat_last = 1'b1;
        inc_ok    = 1'b1;
      end
    end

    if (fresh || close || abort) begin
      cnt_d     = 2'd0;
      crc_d     = 8'h00;
      len_d     = '0;
      emitted_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_HUNT;
      hold0_q   <= '0;
      hold1_q   <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      len_q     <= '0;
      emitted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold0_q   <= hold0_d;
      hold1_q   <= hold1_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      emitted_q <= emitted_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      initiator_tvalid <= 1'b0;
      initiator_tdata  <= '0;
      initiator_tlast  <= 1'b0;
      initiator_tuser  <= '0;
    end else if (beat) begin
      initiator_tvalid <= 1'b1;
      initiator_tdata  <= beat_data;
      initiator_tlast  <= beat_last;
      initiator_tuser  <= beat_user;
    end else if (initiator_tready) begin
      initiator_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frames_ok  <= '0;
      frames_err <= '0;
    end else begin
      if (inc_ok && frames_ok != '1)   frames_ok  <= frames_ok + 16'd1;
      if (inc_err && frames_err != '1) frames_err <= frames_err + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi4s_frame_decoder.sv
// Directed bench for axi4s_frame_decoder (MAX_LEN=4, CRC-8 enabled): stimulus pushes
// expected beats into a queue, a negedge monitor pops and compares each output beat.
module tb_axi4s_frame_decoder;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] user;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        target_tvalid;
  logic        target_tready;
  logic [7:0]  target_tdata;
  logic        initiator_tvalid;
  logic        initiator_tready;
  logic [7:0]  initiator_tdata;
  logic        initiator_tlast;
  logic [1:0]  initiator_tuser;
  logic [15:0] frames_ok;
  logic [15:0] frames_err;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_ok   = 0;
  int    exp_err  = 0;

  axi4s_frame_decoder #(.MAX_LEN(4), .CRC_EN(1'b1), .CRC_POLY(8'h07)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .target_tvalid   (target_tvalid),
    .target_tready   (target_tready),
    .target_tdata    (target_tdata),
    .initiator_tvalid(initiator_tvalid),
    .initiator_tready(initiator_tready),
    .initiator_tdata (initiator_tdata),
    .initiator_tlast (initiator_tlast),
    .initiator_tuser (initiator_tuser),
    .frames_ok       (frames_ok),
    .frames_err      (frames_err)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    beat_t got, want;
    if (!areset && initiator_tvalid && initiator_tready) begin
      got = '{initiator_tdata, initiator_tlast, initiator_tuser};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data=%h last=%b user=%b, required none", got.data, got.last, got.user);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL beat: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                   got.data, got.last, got.user, want.data, want.last, want.user);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic [1:0] u);
    exp_q.push_back('{d, l, u});
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    target_tvalid = 1'b1;
    target_tdata  = b;
    for (int i = 0; i < 100; i++) begin
      ok = target_tready;
      @(posedge aclk);
      #1;
      if (ok) begin
        target_tvalid = 1'b0;
        return;
      end
    end
    target_tvalid = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: byte %h not accepted, required acceptance", b);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    check({name, "_frames_ok"}, frames_ok, exp_ok);
    check({name, "_frames_err"}, frames_err, exp_err);
  endtask

  initial begin
    areset           = 1'b1;
    target_tvalid    = 1'b0;
    target_tdata     = 8'h00;
    initiator_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_tvalid", initiator_tvalid, 0);
    check("reset_tdata", initiator_tdata, 0);
    check("reset_tlast", initiator_tlast, 0);
    check("reset_tuser", initiator_tuser, 0);
    check("reset_frames_ok", frames_ok, 0);
    check("reset_frames_err", frames_err, 0);
    check("reset_target_tready", target_tready, 1);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Good CRC
    expect_beat(8'h01, 1'b0, 2'b00);
    expect_beat(8'h02, 1'b1, 2'b00);
    exp_ok++;
    send_frame('{8'h7D, 8'h01, 8'h02, 8'h1B, 8'h7E});
    drain("good_crc");

    // Bad CRC
    expect_beat(8'h01, 1'b0, 2'b00);
    expect_beat(8'h02, 1'b1, 2'b01);
    exp_err++;
    send_frame('{8'h7D, 8'h01, 8'h02, 8'h1C, 8'h7E});
    drain("bad_crc");

    // Escaped STOP payload and escaped START as CRC
    expect_beat(8'h7E, 1'b1, 2'b00);
    exp_ok++;
    send_frame('{8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7D, 8'h7E});
    drain("escapes");

    // Restart mid-frame, then second frame with bad CRC
    expect_beat(8'h11, 1'b0, 2'b00);
    expect_beat(8'h22, 1'b1, 2'b10);
    expect_beat(8'h44, 1'b1, 2'b01);
    exp_err += 2;
    send_frame('{8'h7D, 8'h11, 8'h22, 8'h33, 8'h7D, 8'h44, 8'hC8, 8'h7E});
    drain("restart");

    // Overflow past MAX_LEN=4; trailing bytes and STOP ignored in hunt
    expect_beat(8'h0A, 1'b0, 2'b00);
    expect_beat(8'h0B, 1'b0, 2'b00);
    expect_beat(8'h0C, 1'b1, 2'b10);
    exp_err++;
    send_frame('{8'h7D, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h7E});
    drain("overflow");

    // Exactly MAX_LEN bytes including CRC is accepted
    expect_beat(8'h01, 1'b0, 2'b00);
    expect_beat(8'h02, 1'b0, 2'b00);
    expect_beat(8'h1B, 1'b1, 2'b00);
    exp_ok++;
    send_frame('{8'h7D, 8'h01, 8'h02, 8'h1B, 8'h00, 8'h7E});
    drain("max_len");

    // Short frames: empty and single byte
    exp_err++;
    send_frame('{8'h7D, 8'h7E});
    drain("short0");
    exp_err++;
    send_frame('{8'h7D, 8'h55, 8'h7E});
    drain("short1");

    // Backpressure: first beat stalls for 5 cycles
    initiator_tready = 1'b0;
    expect_beat(8'h11, 1'b0, 2'b00);
    send_frame('{8'h7D, 8'h11, 8'h22, 8'h33});
    for (int i = 0; i < 5; i++) begin
      check("stall_target_tready", target_tready, 0);
      check("stall_tvalid", initiator_tvalid, 1);
      check("stall_tdata", initiator_tdata, 8'h11);
      check("stall_tlast", initiator_tlast, 0);
      @(posedge aclk);
      #1;
    end
    initiator_tready = 1'b1;
    drain("stall");

    // Reset mid-frame (22 33 still held): nothing emitted, counters cleared
    areset = 1'b1;
    #1;
    check("midreset_tvalid", initiator_tvalid, 0);
    check("midreset_tdata", initiator_tdata, 0);
    check("midreset_tlast", initiator_tlast, 0);
    check("midreset_tuser", initiator_tuser, 0);
    check("midreset_frames_ok", frames_ok, 0);
    check("midreset_frames_err", frames_err, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
    expect_beat(8'h01, 1'b0, 2'b00);
    expect_beat(8'h02, 1'b1, 2'b00);
    exp_ok++;
    send_frame('{8'h7D, 8'h01, 8'h02, 8'h1B, 8'h7E});
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
